// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter: puts the instruction-fetch and data-access requesters onto
// one SRAM-like memory port, with one transaction in flight at a time.
// Data accesses win ties. Fetch is forced through once it has lost
// STARVE_LIMIT consecutive ties.
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | no transaction in flight; grant evaluated combinationally
// REQ   | mem_req high with latched payload, waiting for mem_addr_ok
// WAIT  | address accepted, waiting for mem_data_ok to complete to owner
module sram_req_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    input  logic [1:0]  inst_size,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic             owner, owner_nxt;
    logic [CNT_W-1:0] starve_cnt, starve_nxt;

    logic             lat_wr;
    logic [1:0]       lat_size;
    logic [3:0]       lat_wstrb;
    logic [31:0]      lat_addr;
    logic [31:0]      lat_wdata;

    logic             pay_wr;
    logic [1:0]       pay_size;
    logic [3:0]       pay_wstrb;
    logic [31:0]      pay_addr;
    logic [31:0]      pay_wdata;

    logic             grant_inst;
    logic             grant_data;
    logic             load;
    logic             complete;

    // Grant selection, starvation accounting and transaction sequencing.
    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        starve_nxt = starve_cnt;
        grant_inst = 1'b0;
        grant_data = 1'b0;
        load       = 1'b0;
        complete   = 1'b0;
        case (state)
            IDLE: begin
                grant_inst = inst_req && (!data_req || (starve_cnt == CNT_MAX));
                grant_data = data_req && !grant_inst;
                if (grant_inst || grant_data) begin
                    load      = 1'b1;
                    owner_nxt = grant_data;
                    state_nxt = REQ;
                    // Only a data grant that leaves fetch waiting counts
                    // toward starvation; anything else starts over.
                    if (grant_data && inst_req) begin
                        starve_nxt = (starve_cnt == CNT_MAX) ? starve_cnt
                                                             : starve_cnt + CNT_W'(1);
                    end else begin
                        starve_nxt = '0;
                    end
                end
            end
            REQ: begin
                if (mem_addr_ok) begin
                    if (mem_data_ok) begin
                        complete  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (mem_data_ok) begin
                    complete  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Payload of the granted requester; fetch is always a plain read.
    always_comb begin
        pay_wr    = 1'b0;
        pay_size  = inst_size;
        pay_wstrb = 4'b0000;
        pay_addr  = inst_addr;
        pay_wdata = 32'h0;
        if (grant_data) begin
            pay_wr    = data_wr;
            pay_size  = data_size;
            pay_wstrb = data_wstrb;
            pay_addr  = data_addr;
            pay_wdata = data_wdata;
        end
    end

    // State, owner, starvation count and latched payload registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            starve_cnt <= '0;
            lat_wr     <= 1'b0;
            lat_size   <= 2'b00;
            lat_wstrb  <= 4'b0000;
            lat_addr   <= 32'h0;
            lat_wdata  <= 32'h0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            starve_cnt <= starve_nxt;
            if (load) begin
                lat_wr    <= pay_wr;
                lat_size  <= pay_size;
                lat_wstrb <= pay_wstrb;
                lat_addr  <= pay_addr;
                lat_wdata <= pay_wdata;
            end
        end
    end

    // Requester-side handshakes; completion goes only to the owner.
    always_comb begin
        inst_addr_ok = grant_inst;
        data_addr_ok = grant_data;
        inst_data_ok = complete && !owner;
        data_data_ok = complete && owner;
        inst_rdata   = mem_rdata;
        data_rdata   = mem_rdata;
    end

    // Memory-side request; fields held from the latch so they stay stable.
    always_comb begin
        mem_req   = (state == REQ);
        mem_wr    = lat_wr;
        mem_size  = lat_size;
        mem_wstrb = lat_wstrb;
        mem_addr  = lat_addr;
        mem_wdata = lat_wdata;
    end

endmodule
